timer_seq_arb: RTL and testbench

- Round-robin scheduler that shares one `advanced_timer_simple` instance between NREQ requesters.
- Per granted request it serialises the start pattern 1101 and a 4-bit delay onto the timer's data line, MSB first.
- It then waits for `counting` and then `done`, handshakes `ack`, and returns a one-cycle completion pulse to the owner.
- It sits between client logic and the timer; it is the only driver of the timer's `data` and `ack` pins.

---
 rtl/timer_seq_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/timer_seq_arb.sv | 168 ++++++++++++++++
 tb/tb_timer_seq_arb.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_seq_pkg.sv
// Shared definitions for the timer sequencer: FSM state codes, the start
// pattern the timer looks for, and the width of one client's delay field.
package timer_seq_pkg;

    localparam int         DELAY_W       = 4;
    localparam logic [3:0] START_PATTERN = 4'b1101;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_CNT  = 3'd2,
        WAIT_DONE = 3'd3,
        ACK       = 3'd4,
        ERR       = 3'd5
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search. The scan starts one position
// after rr_ptr and wraps at NREQ, so the last owner becomes lowest priority.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   index,
    output logic            valid
);

    // First set request at distance 1..NREQ from the pointer wins.
    always_comb begin
        onehot = '0;
        index  = '0;
        valid  = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!valid && req[i] && (i == ((int'(rr_ptr) + off) % NREQ))) begin
                    valid     = 1'b1;
                    onehot[i] = 1'b1;
                    index     = PW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/timer_seq_arb.sv
// Round-robin front end for a single shared timer. A granted client's delay
// is framed behind the start pattern and shifted out MSB first; the FSM then
// follows the timer through counting/done, handshakes ack and pulses fin.
module timer_seq_arb
    import timer_seq_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int CNT_TIMEOUT = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [DELAY_W*NREQ-1:0] delay_in,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         fin,
    output logic                    busy,
    output logic                    err,
    output logic                    timer_data,
    output logic                    timer_ack,
    input  logic                    timer_counting,
    input  logic                    timer_done
);

    localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMO_MAX = (CNT_TIMEOUT > ACK_TIMEOUT) ? CNT_TIMEOUT : ACK_TIMEOUT;
    localparam int TMO_W   = $clog2(TMO_MAX) + 1;

    state_t             state_reg,   state_next;
    logic [NREQ-1:0]    grant_reg,   grant_next;
    logic [NREQ-1:0]    fin_reg,     fin_next;
    logic               err_reg,     err_next;
    logic [7:0]         shreg_reg,   shreg_next;
    logic [2:0]         bit_cnt_reg, bit_cnt_next;
    logic [TMO_W-1:0]   tmo_reg,     tmo_next;
    logic [PW-1:0]      rr_ptr_reg,  rr_ptr_next;

    logic [NREQ-1:0]    win_onehot;
    logic [PW-1:0]      win_idx;
    logic               win_valid;
    logic [DELAY_W-1:0] delay_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_delay
            assign delay_arr[gi] = delay_in[gi*DELAY_W +: DELAY_W];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .onehot (win_onehot),
        .index  (win_idx),
        .valid  (win_valid)
    );

    // State register; everything the pins see drops as soon as reset asserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            fin_reg     <= '0;
            err_reg     <= 1'b0;
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
            tmo_reg     <= '0;
            rr_ptr_reg  <= PW'(NREQ - 1);
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            fin_reg     <= fin_next;
            err_reg     <= err_next;
            shreg_reg   <= shreg_next;
            bit_cnt_reg <= bit_cnt_next;
            tmo_reg     <= tmo_next;
            rr_ptr_reg  <= rr_ptr_next;
        end
    end

    // Next-state logic: arbitrate, shift the frame, then track the timer.
    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        fin_next     = '0;
        err_next     = err_reg;
        shreg_next   = shreg_reg;
        bit_cnt_next = bit_cnt_reg;
        tmo_next     = tmo_reg;
        rr_ptr_next  = rr_ptr_reg;

        case (state_reg)
            IDLE: begin
                if (win_valid && !err_reg) begin
                    grant_next   = win_onehot;
                    shreg_next   = {START_PATTERN, delay_arr[win_idx]};
                    rr_ptr_next  = win_idx;
                    bit_cnt_next = '0;
                    state_next   = SEND;
                end
            end
            SEND: begin
                shreg_next   = {shreg_reg[6:0], 1'b0};
                bit_cnt_next = bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) begin
                    tmo_next   = '0;
                    state_next = WAIT_CNT;
                end
            end
            WAIT_CNT: begin
                // done before counting means the timer is out of step with us
                if (timer_done) begin
                    grant_next = '0;
                    err_next   = 1'b1;
                    state_next = ERR;
                end else if (timer_counting) begin
                    state_next = WAIT_DONE;
                end else if (tmo_reg == TMO_W'(CNT_TIMEOUT - 1)) begin
                    grant_next = '0;
                    err_next   = 1'b1;
                    state_next = ERR;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            WAIT_DONE: begin
                // no timeout here: a full-length count is thousands of cycles
                if (timer_done) begin
                    tmo_next   = '0;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!timer_done) begin
                    fin_next   = grant_reg;
                    grant_next = '0;
                    state_next = IDLE;
                end else if (tmo_reg == TMO_W'(ACK_TIMEOUT - 1)) begin
                    grant_next = '0;
                    err_next   = 1'b1;
                    state_next = ERR;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            ERR: begin
                grant_next = '0;
                err_next   = 1'b1;
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign grant      = grant_reg;
    assign fin        = fin_reg;
    assign err        = err_reg;
    assign busy       = (state_reg != IDLE);
    // data is forced low outside SEND so the timer never sees a stray frame
    assign timer_data = (state_reg == SEND) & shreg_reg[7];
    assign timer_ack  = (state_reg == ACK);

endmodule

// File: tb/tb_timer_seq_arb.sv
// Testbench for timer_seq_arb: behavioural timer, round-robin reference
// model feeding a scoreboard queue, independent monitor, directed phases
// for the timeout/reset corners and a randomized traffic phase.
module tb_timer_seq_arb;

    localparam int NREQ        = 4;
    localparam int CNT_TIMEOUT = 4;
    localparam int ACK_TIMEOUT = 8;
    // compressed time base for the timer model: (delay+1)*SCALE cycles
    localparam int SCALE       = 20;

    localparam int T_SRCH = 0;
    localparam int T_DLY  = 1;
    localparam int T_CNT  = 2;
    localparam int T_DONE = 3;
    localparam int T_DEAD = 4;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [4*NREQ-1:0]   delay_in;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     fin;
    logic                busy;
    logic                err;
    logic                timer_data;
    logic                timer_ack;
    logic                timer_counting;
    logic                timer_done;

    bit mode_nocnt;
    bit mode_hold;
    bit mode_early;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct packed {
        int         client;
        logic [3:0] delay;
    } txn_t;

    txn_t exp_q[$];

    timer_seq_arb #(
        .NREQ        (NREQ),
        .CNT_TIMEOUT (CNT_TIMEOUT),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .delay_in       (delay_in),
        .grant          (grant),
        .fin            (fin),
        .busy           (busy),
        .err            (err),
        .timer_data     (timer_data),
        .timer_ack      (timer_ack),
        .timer_counting (timer_counting),
        .timer_done     (timer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, want, $time);
        end
    endtask

    // Behavioural timer: hunts for 1101, takes 4 delay bits, counts, raises
    // done and drops it once ack is seen. Mode bits inject the faulty timers.
    initial begin : timer_model
        int         tstate;
        int         nb;
        int         cnt;
        logic [3:0] win;
        logic [3:0] dbits;
        tstate = T_SRCH; nb = 0; cnt = 0; win = '0; dbits = '0;
        timer_counting = 1'b0;
        timer_done     = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                tstate = T_SRCH; win = '0; nb = 0;
                timer_counting = 1'b0;
                timer_done     = 1'b0;
                continue;
            end
            case (tstate)
                T_SRCH: begin
                    win = {win[2:0], timer_data};
                    if (win == 4'b1101) begin
                        tstate = T_DLY; nb = 0; dbits = '0;
                    end
                end
                T_DLY: begin
                    dbits = {dbits[2:0], timer_data};
                    nb++;
                    if (nb == 4) begin
                        if (mode_early) begin
                            timer_done = 1'b1; tstate = T_DONE;
                        end else if (mode_nocnt) begin
                            tstate = T_DEAD;
                        end else begin
                            timer_counting = 1'b1;
                            cnt = (int'(dbits) + 1) * SCALE;
                            tstate = T_CNT;
                        end
                    end
                end
                T_CNT: begin
                    cnt--;
                    if (cnt == 0) begin
                        timer_counting = 1'b0; timer_done = 1'b1; tstate = T_DONE;
                    end
                end
                T_DONE: begin
                    if (timer_ack && !mode_hold) begin
                        timer_done = 1'b0; win = '0; tstate = T_SRCH;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reference model: whenever the sequencer is free, the next grant goes to
    // the first requester after the previous owner (cyclically), carrying the
    // delay presented at that moment.
    initial begin : ref_model
        bit   idle;
        int   last;
        int   c;
        txn_t t;
        idle = 1'b1; last = NREQ - 1;
        forever begin
            @(negedge clk); #1;
            if (!reset) begin
                exp_q.delete(); idle = 1'b1; last = NREQ - 1;
                continue;
            end
            if (fin != '0) idle = 1'b1;
            if (idle && req != '0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    c = (last + k) % NREQ;
                    if (req[c]) begin
                        t.client = c;
                        t.delay  = delay_in[4*c +: 4];
                        exp_q.push_back(t);
                        last = c;
                        idle = 1'b0;
                        break;
                    end
                end
            end
        end
    end

    // Monitor: pops the expected transaction at each new grant and checks
    // owner, the 8 serial bits, the idle data line and the fin pulse.
    initial begin : monitor
        logic [NREQ-1:0] g_prev;
        logic [NREQ-1:0] f_prev;
        logic [NREQ-1:0] cur_oh;
        logic [7:0]      got;
        logic [7:0]      want;
        int              nbits;
        bit              coll;
        txn_t            t;
        g_prev = '0; f_prev = '0; cur_oh = '0; got = '0; want = '0; nbits = 0; coll = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (!reset) begin
                g_prev = '0; f_prev = '0; cur_oh = '0; coll = 1'b0;
                continue;
            end
            if (grant != '0 && g_prev == '0) begin
                check("sb_pending", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() > 0) begin
                    t = exp_q.pop_front();
                    cur_oh = '0;
                    cur_oh[t.client] = 1'b1;
                    check("grant_owner", 32'(grant), 32'(cur_oh));
                    want  = {4'b1101, t.delay};
                    nbits = 0;
                    coll  = 1'b1;
                end
            end else if (grant != '0) begin
                check("grant_hold", 32'(grant), 32'(cur_oh));
            end
            if (coll) begin
                got[7-nbits] = timer_data;
                nbits++;
                if (nbits == 8) begin
                    check("serial_word", 32'(got), 32'(want));
                    coll = 1'b0;
                end
            end else begin
                check("data_idle", 32'(timer_data), 32'd0);
            end
            if (fin != '0) begin
                check("fin_owner", 32'(fin), 32'(cur_oh));
                check("fin_busy", 32'(busy), 32'd0);
                check("fin_grant", 32'(grant), 32'd0);
            end
            if (f_prev != '0) check("fin_width", 32'(fin), 32'd0);
            g_prev = grant;
            f_prev = fin;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; req = '0; delay_in = '0;
        mode_nocnt = 1'b0; mode_hold = 1'b0; mode_early = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_grant(input int budget);
        int n = 0;
        while (grant == '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("grant_timeout", 32'(grant != '0), 32'd1);
    endtask

    task automatic wait_fin(input int budget, output logic [NREQ-1:0] f);
        int n = 0;
        while (fin == '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("fin_timeout", 32'(fin != '0), 32'd1);
        f = fin;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [NREQ-1:0] f;
        logic [NREQ-1:0] e;
        int              n;

        reset = 1'b0; req = '0; delay_in = '0;
        mode_nocnt = 1'b0; mode_hold = 1'b0; mode_early = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_fin", 32'(fin), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_data", 32'(timer_data), 32'd0);
        check("rst_ack", 32'(timer_ack), 32'd0);
        reset = 1'b1;

        // single request, delay 2, one-cycle grant latency
        @(posedge clk); #1;
        delay_in[3:0] = 4'd2; req = 4'b0001;
        @(negedge clk);
        check("lat_before", 32'(grant), 32'd0);
        @(negedge clk);
        check("lat_grant", 32'(grant), 32'd1);
        check("busy_send", 32'(busy), 32'd1);
        wait_fin(2000, f);
        req = '0;
        check("single_fin", 32'(f), 32'd1);
        @(negedge clk);
        check("busy_after", 32'(busy), 32'd0);

        // all clients requesting continuously: rotation 0,1,2,3,0
        do_reset();
        @(posedge clk); #1;
        delay_in = {4'd3, 4'd2, 4'd1, 4'd0};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_fin(2000, f);
            e = '0;
            e[k % NREQ] = 1'b1;
            check("rr_order", 32'(f), 32'(e));
            if (k == 4) req = '0;
            @(negedge clk);
        end

        // delay change and req drop after grant are ignored
        do_reset();
        @(posedge clk); #1;
        delay_in[11:8] = 4'hF; req = 4'b0100;
        wait_grant(10);
        @(posedge clk); #1;
        delay_in[11:8] = 4'h0; req = '0;
        wait_fin(2000, f);
        check("late_fin", 32'(f), 32'(4'b0100));
        @(negedge clk);

        // randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (fin[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[i] = 1'b1;
                        delay_in[4*i +: 4] = 4'($urandom);
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (grant[i]) begin
                    if ($urandom_range(0, 7) == 0) delay_in[4*i +: 4] = 4'($urandom);
                    if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 7) == 0) begin
                    delay_in[4*i +: 4] = 4'($urandom);
                    req[i] = 1'b1;
                end
            end
        end
        n = 0;
        while ((req != '0 || busy) && n < 20000) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) if (fin[i]) req[i] = 1'b0;
            n++;
        end
        check("drain_timeout", 32'(req == '0 && !busy), 32'd1);

        // counting never rises: error four cycles after the last bit
        do_reset();
        mode_nocnt = 1'b1;
        @(posedge clk); #1;
        req = 4'b0001;
        wait_grant(10);
        repeat (11) @(negedge clk);
        check("cnt_err_early", 32'(err), 32'd0);
        @(negedge clk);
        check("cnt_err", 32'(err), 32'd1);
        check("cnt_grant", 32'(grant), 32'd0);
        check("cnt_busy", 32'(busy), 32'd1);
        check("cnt_ack", 32'(timer_ack), 32'd0);
        @(posedge clk); #1;
        req = 4'b0010;
        repeat (20) @(negedge clk);
        check("err_no_grant", 32'(grant), 32'd0);
        check("err_sticky", 32'(err), 32'd1);

        // done never falls: error after ACK_TIMEOUT cycles of ack
        do_reset();
        mode_hold = 1'b1;
        @(posedge clk); #1;
        req = 4'b0001;
        n = 0;
        while (!timer_ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ack_wait", 32'(timer_ack), 32'd1);
        repeat (ACK_TIMEOUT - 1) @(negedge clk);
        check("ack_err_early", 32'(err), 32'd0);
        check("ack_held", 32'(timer_ack), 32'd1);
        @(negedge clk);
        check("ack_err", 32'(err), 32'd1);
        check("ack_dropped", 32'(timer_ack), 32'd0);
        check("ack_grant", 32'(grant), 32'd0);

        // reset in the middle of SEND, then a clean transaction
        do_reset();
        @(posedge clk); #1;
        delay_in[3:0] = 4'd5; req = 4'b0001;
        wait_grant(10);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_data", 32'(timer_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        delay_in[3:0] = 4'd9; req = 4'b0001;
        wait_fin(2000, f);
        req = '0;
        check("post_rst_fin", 32'(f), 32'd1);

        // done while still waiting for counting
        do_reset();
        mode_early = 1'b1;
        @(posedge clk); #1;
        req = 4'b0001;
        n = 0;
        while (!err && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("early_done_err", 32'(err), 32'd1);
        check("early_done_grant", 32'(grant), 32'd0);

        do_reset();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
